// File: rtl/dual_core_dispatch_queue.sv
// Per-core instruction dispatch queues: captures arbiter-steered instructions into two
// show-ahead circular FIFOs and presents each head to its core over valid/ready.
module dual_core_dispatch_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [WIDTH-1:0]             instr_in,
  input  logic                         fifo_1_en,
  input  logic                         fifo_2_en,
  input  logic                         flush,
  output logic [WIDTH-1:0]             core1_instr,
  output logic                         core1_valid,
  input  logic                         core1_ready,
  output logic [WIDTH-1:0]             core2_instr,
  output logic                         core2_valid,
  input  logic                         core2_ready,
  output logic [$clog2(DEPTH+1)-1:0]   q1_count,
  output logic [$clog2(DEPTH+1)-1:0]   q2_count,
  output logic                         q1_full,
  output logic                         q2_full,
  output logic                         stall_out,
  output logic                         err_overflow,
  output logic                         err_both_en
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  logic [PW-1:0]    rd_ptr_q [2];
  logic [PW-1:0]    rd_ptr_d [2];
  logic [PW-1:0]    wr_ptr_q [2];
  logic [PW-1:0]    wr_ptr_d [2];
  logic [CW-1:0]    count_q  [2];
  logic [CW-1:0]    count_d  [2];
  logic [WIDTH-1:0] mem_q    [2][DEPTH];

  logic err_overflow_q, err_overflow_d;
  logic err_both_en_q, err_both_en_d;

  logic [1:0] en, ready, valid, push_req, push_ok, pop;
  logic       single_en;

  assign en        = {fifo_2_en, fifo_1_en};
  assign ready     = {core2_ready, core1_ready};
  assign single_en = fifo_1_en ^ fifo_2_en;

  always_comb begin
    err_overflow_d = err_overflow_q;
    err_both_en_d  = err_both_en_q | (fifo_1_en & fifo_2_en);
    valid          = '0;
    push_req       = '0;
    push_ok        = '0;
    pop            = '0;
    for (int k = 0; k < 2; k++) begin
      valid[k]    = (count_q[k] != '0);
      push_req[k] = en[k] & single_en & ~flush;
      pop[k]      = valid[k] & ready[k] & ~flush;
      // A full queue still accepts when its head leaves in the same cycle.
      push_ok[k]  = push_req[k] & ((count_q[k] != FullCnt) | pop[k]);
      if (push_req[k] && !push_ok[k]) begin
        err_overflow_d = 1'b1;
      end

      rd_ptr_d[k] = rd_ptr_q[k] + PW'(pop[k]);
      wr_ptr_d[k] = wr_ptr_q[k] + PW'(push_ok[k]);
      case ({push_ok[k], pop[k]})
        2'b10:   count_d[k] = count_q[k] + CW'(1);
        2'b01:   count_d[k] = count_q[k] - CW'(1);
        default: count_d[k] = count_q[k];
      endcase

      if (flush) begin
        rd_ptr_d[k] = '0;
        wr_ptr_d[k] = '0;
        count_d[k]  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < 2; k++) begin
        rd_ptr_q[k] <= '0;
        wr_ptr_q[k] <= '0;
        count_q[k]  <= '0;
      end
      err_overflow_q <= 1'b0;
      err_both_en_q  <= 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        rd_ptr_q[k] <= rd_ptr_d[k];
        wr_ptr_q[k] <= wr_ptr_d[k];
        count_q[k]  <= count_d[k];
      end
      err_overflow_q <= err_overflow_d;
      err_both_en_q  <= err_both_en_d;
    end
  end

  // Storage is not reset; valid gating keeps stale contents off the core buses.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (resetn && push_ok[k]) begin
        mem_q[k][wr_ptr_q[k]] <= instr_in;
      end
    end
  end

  assign core1_valid  = valid[0];
  assign core2_valid  = valid[1];
  assign core1_instr  = valid[0] ? mem_q[0][rd_ptr_q[0]] : '0;
  assign core2_instr  = valid[1] ? mem_q[1][rd_ptr_q[1]] : '0;
  assign q1_count     = count_q[0];
  assign q2_count     = count_q[1];
  assign q1_full      = (count_q[0] == FullCnt);
  assign q2_full      = (count_q[1] == FullCnt);
  assign stall_out    = q1_full | q2_full;
  assign err_overflow = err_overflow_q;
  assign err_both_en  = err_both_en_q;

endmodule

// File: tb/tb_dual_core_dispatch_queue.sv
// Randomised and directed bench for dual_core_dispatch_queue, checked by a queue-based
// scoreboard sampled mid-cycle.
module tb_dual_core_dispatch_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             resetn;
  logic [WIDTH-1:0] instr_in;
  logic             fifo_1_en, fifo_2_en, flush;
  logic [WIDTH-1:0] core1_instr, core2_instr;
  logic             core1_valid, core2_valid, core1_ready, core2_ready;
  logic [CW-1:0]    q1_count, q2_count;
  logic             q1_full, q2_full, stall_out, err_overflow, err_both_en;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dual_core_dispatch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .instr_in     (instr_in),
    .fifo_1_en    (fifo_1_en),
    .fifo_2_en    (fifo_2_en),
    .flush        (flush),
    .core1_instr  (core1_instr),
    .core1_valid  (core1_valid),
    .core1_ready  (core1_ready),
    .core2_instr  (core2_instr),
    .core2_valid  (core2_valid),
    .core2_ready  (core2_ready),
    .q1_count     (q1_count),
    .q2_count     (q2_count),
    .q1_full      (q1_full),
    .q2_full      (q2_full),
    .stall_out    (stall_out),
    .err_overflow (err_overflow),
    .err_both_en  (err_both_en)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one ordered list of expected entries per core plus sticky flags.
  logic [31:0] exp_q1[$];
  logic [31:0] exp_q2[$];
  logic        m_ovf = 1'b0;
  logic        m_both = 1'b0;
  logic        armed = 1'b0;

  always @(negedge clk) begin
    int  n1, n2;
    logic pop1, pop2;
    if (armed) begin
      n1 = exp_q1.size();
      n2 = exp_q2.size();
      chk("q1_count", 32'(q1_count), 32'(n1));
      chk("q2_count", 32'(q2_count), 32'(n2));
      chk("core1_valid", 32'(core1_valid), 32'(n1 != 0));
      chk("core2_valid", 32'(core2_valid), 32'(n2 != 0));
      chk("core1_instr", core1_instr, (n1 != 0) ? exp_q1[0] : 32'h0);
      chk("core2_instr", core2_instr, (n2 != 0) ? exp_q2[0] : 32'h0);
      chk("q1_full", 32'(q1_full), 32'(n1 == DEPTH));
      chk("q2_full", 32'(q2_full), 32'(n2 == DEPTH));
      chk("stall_out", 32'(stall_out), 32'((n1 == DEPTH) || (n2 == DEPTH)));
      chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
      chk("err_both_en", 32'(err_both_en), 32'(m_both));
    end
    // Advance the model with the inputs that the coming rising edge will see.
    if (!resetn) begin
      exp_q1.delete();
      exp_q2.delete();
      m_ovf  = 1'b0;
      m_both = 1'b0;
      armed  = 1'b1;
    end else if (flush) begin
      exp_q1.delete();
      exp_q2.delete();
    end else begin
      n1   = exp_q1.size();
      n2   = exp_q2.size();
      pop1 = (n1 != 0) && core1_ready;
      pop2 = (n2 != 0) && core2_ready;
      if (fifo_1_en && fifo_2_en) m_both = 1'b1;
      if (pop1) void'(exp_q1.pop_front());
      if (pop2) void'(exp_q2.pop_front());
      if (fifo_1_en && !fifo_2_en) begin
        if (n1 < DEPTH || pop1) exp_q1.push_back(instr_in);
        else m_ovf = 1'b1;
      end
      if (fifo_2_en && !fifo_1_en) begin
        if (n2 < DEPTH || pop2) exp_q2.push_back(instr_in);
        else m_ovf = 1'b1;
      end
    end
  end

  task automatic cyc(input logic [31:0] d, input logic e1, input logic e2, input logic r1,
                     input logic r2, input logic fl, input logic rn);
    instr_in    = d;
    fifo_1_en   = e1;
    fifo_2_en   = e2;
    core1_ready = r1;
    core2_ready = r2;
    flush       = fl;
    resetn      = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    instr_in = '0; fifo_1_en = 0; fifo_2_en = 0; flush = 0;
    core1_ready = 0; core2_ready = 0; resetn = 0;
    @(posedge clk); #1;
    cyc(32'h0, 0, 0, 0, 0, 0, 0);

    // Basic steering to each core.
    cyc(32'h10000001, 1, 0, 0, 0, 0, 1);
    cyc(32'h18000002, 0, 1, 0, 0, 0, 1);
    idle(2);

    // Fill queue 1, overflow, then drain in order.
    cyc(32'h0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(32'hA0 + i, 1, 0, 0, 0, 0, 1);
    cyc(32'hA8, 1, 0, 0, 0, 0, 1);
    idle(1);
    for (int i = 0; i < 8; i++) cyc(32'h0, 0, 0, 1, 0, 0, 1);
    idle(1);

    // Full pass-through, then drain across the pointer wrap.
    for (int i = 0; i < 8; i++) cyc(32'hA0 + i, 1, 0, 0, 0, 0, 1);
    cyc(32'hB0, 1, 0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(32'hC0 + i, 1, 0, 1, 0, 0, 1);
    for (int i = 0; i < 9; i++) cyc(32'h0, 0, 0, 1, 0, 0, 1);

    // Both enables together.
    cyc(32'hDEADBEEF, 1, 1, 0, 0, 0, 1);
    idle(3);

    // Flush with concurrent push and pop.
    cyc(32'h0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(32'h300 + i, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(32'h500 + i, 0, 1, 0, 0, 0, 1);
    cyc(32'hF1F1F1F1, 1, 0, 0, 1, 1, 1);
    idle(2);

    // Reset mid-stream with errors set.
    for (int i = 0; i < 4; i++) cyc(32'h400 + i, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) cyc(32'h200 + i, 0, 1, 0, 0, 0, 1);
    cyc(32'hDEADBEEF, 1, 1, 0, 0, 0, 1);
    cyc(32'h77777777, 1, 0, 1, 1, 0, 0);
    cyc(32'h11111111, 1, 0, 0, 0, 0, 1);
    idle(2);

    // Randomised traffic with varying back-pressure.
    for (int seg = 0; seg < 15; seg++) begin
      int p1, p2;
      p1 = $urandom_range(0, 100);
      p2 = $urandom_range(0, 100);
      for (int i = 0; i < 200; i++) begin
        int   v;
        logic e1, e2;
        v  = $urandom_range(0, 15);
        e1 = (v == 0) || (v >= 1 && v <= 6);
        e2 = (v == 0) || (v >= 7 && v <= 12);
        cyc($urandom, e1, e2,
            ($urandom_range(0, 99) < p1), ($urandom_range(0, 99) < p2),
            ($urandom_range(0, 63) == 0), ($urandom_range(0, 499) != 0));
      end
    end

    idle(2);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_core_dispatch_queue.md
Name: dual_core_dispatch_queue

Overview:
Receiving end of the dual-core instruction dispatch path. It captures each 32-bit instruction the dispatch arbiter steers to core 1 or core 2 (one-hot enable per cycle) into a per-core FIFO. It presents each FIFO head to its core's fetch/issue stage over a valid/ready handshake, preserving per-core program order. It returns full/stall status to the arbiter and raises sticky error flags on protocol violations.

Parameters:
DEPTH, 8, entries per core queue; power of two, >= 2.
WIDTH, 32, instruction width in bits.

Ports:
clk  input  1  rising-edge clock
resetn  input  1  synchronous, active-low reset
instr_in  input  WIDTH  instruction from arbiter
fifo_1_en  input  1  push instr_in into queue 1 this cycle
fifo_2_en  input  1  push instr_in into queue 2 this cycle
flush  input  1  synchronous clear of both queues (pipeline redirect)
core1_instr  output  WIDTH  head of queue 1
core1_valid  output  1  queue 1 non-empty
core1_ready  input  1  core 1 accepts head
core2_instr  output  WIDTH  head of queue 2
core2_valid  output  1  queue 2 non-empty
core2_ready  input  1  core 2 accepts head
q1_count  output  $clog2(DEPTH+1)  queue 1 occupancy
q2_count  output  $clog2(DEPTH+1)  queue 2 occupancy
q1_full  output  1  q1_count == DEPTH
q2_full  output  1  q2_count == DEPTH
stall_out  output  1  q1_full | q2_full; arbiter must hold dispatch
err_overflow  output  1  sticky: push refused on a full queue
err_both_en  output  1  sticky: fifo_1_en and fifo_2_en high together

Behaviour:
- Reset (resetn low at rising edge): pointers, counts, and both error flags go to 0. Valid, full, and stall_out are 0. core*_instr is 0. Storage contents are don't-care. Reset overrides every other input, including mid-stream.
- Each queue is an independent circular buffer with rd_ptr, wr_ptr, and count.
  - Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
- Push to queue k:
  - Occurs when fifo_k_en=1, the other enable=0, and flush=0.
  - Accepted when count_k < DEPTH, OR when count_k == DEPTH and a pop of queue k occurs in the same cycle (full pass-through).
  - Accepted push: writes mem_k[wr_ptr_k] and increments wr_ptr_k.
  - Refused push: data is dropped, no state change, err_overflow set to 1.
- Pop of queue k: core_k_valid && core_k_ready at the clock edge; increments rd_ptr_k.
- Count update per queue: +1 on push only, -1 on pop only, unchanged on push+pop or on neither.
- Head presentation is show-ahead:
  - core_k_instr = mem_k[rd_ptr_k] when core_k_valid, else 0.
  - core_k_valid = (count_k != 0).
  - All derived from registered state; no combinational path from instr_in or enables to core outputs.
- Latency: a push accepted at edge N makes the entry visible at the core interface immediately after edge N. Empty-to-valid takes 1 cycle.
- Empty queue: ready is ignored; no pop and no underflow.
- Simultaneous push+pop on an empty queue: the pop is not possible (valid=0). The push lands and valid rises next cycle.
- Both enables high:
  - Neither queue is written and err_both_en is set.
  - Pops still proceed normally.
  - err_overflow is not set by this event.
- Flush = 1 at an edge:
  - Both queues' rd_ptr, wr_ptr, and count go to 0 and valids drop next cycle.
  - Any concurrent push or pop is discarded.
  - Error flags are not cleared.
- Error flags clear only on reset.
- stall_out, full, and count outputs are registered-state-derived (combinational from count). The arbiter samples them the same cycle.
- Per-core ordering: entries pop in exactly the order pushed. No cross-queue reordering occurs.

Test Plan:
- Reset then push 0x10000001 (en1), 0x18000002 (en2) on consecutive cycles with ready=0 -> next cycle core1_valid=1, core1_instr=0x10000001, core2_valid=1, core2_instr=0x18000002, q1_count=1, q2_count=1.
- Push 8 words 0xA0..0xA7 to queue 1 with core1_ready=0 -> q1_full=1, stall_out=1. A 9th push 0xA8 -> err_overflow=1, q1_count stays 8. Then ready=1 for 8 cycles -> core1_instr sequence 0xA0..0xA7, then core1_valid=0.
- Hold queue 1 full, push 0xB0 with core1_ready=1 in the same cycle -> 0xA0 popped, 0xB0 accepted, q1_count stays 8, err_overflow unchanged. Drain 12 more entries across the pointer wrap -> correct order, no corruption.
- fifo_1_en=fifo_2_en=1 with instr_in=0xDEADBEEF -> neither count changes, err_both_en=1, and it stays 1 until resetn=0.
- Queues at counts 3/5, assert flush with a concurrent en1 push and core2_ready=1 -> next cycle both counts=0, both valids=0, flushed data never appears.
- Reset asserted mid-stream (counts 4/2, errors set) -> all outputs 0 next cycle. A push 0x11111111 after release appears as core1_instr one cycle later.
